// File: rtl/apb_csr_ctrl_mp.sv
// rtl/apb_csr_ctrl_mp.sv - APB CSR front end for the ALU: operand/opcode storage, FIFO_IN command push, FIFO_OUT result pop
module apb_csr_ctrl_mp #(
  parameter int NUM_OPERANDS   = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int OPERATION_SIZE = 2,
  parameter logic [2**OPERATION_SIZE-1:0] OP_VALID_MASK = 4'b0110,
  parameter int FIFO_OUT_WIDTH = 32,
  parameter int APB_BUS_SIZE   = 32,
  parameter int READ_LATENCY   = 1,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH     = $clog2(NUM_OPERANDS + 3)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          psel,
  input  logic                                          penable,
  input  logic                                          pwrite,
  input  logic [ADDR_WIDTH-1:0]                         paddr,
  input  logic [APB_BUS_SIZE-1:0]                       pwdata,
  output logic [APB_BUS_SIZE-1:0]                       prdata,
  output logic                                          pready,
  output logic                                          pslverr,
  input  logic                                          fifo_in_full,
  output logic                                          fifo_in_wen,
  output logic [OPERATION_SIZE+NUM_OPERANDS*DATA_WIDTH-1:0] fifo_in_wdata,
  input  logic                                          fifo_out_empty,
  output logic                                          fifo_out_ren,
  input  logic [FIFO_OUT_WIDTH-1:0]                     fifo_out_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam int CMD_W = OPERATION_SIZE + NUM_OPERANDS * DATA_WIDTH;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT = ADDR_WIDTH'(NUM_OPERANDS + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(NUM_OPERANDS + 2);

  state_t state, state_nxt;
  logic [CNT_W-1:0]          wait_cnt;
  logic [OPERATION_SIZE-1:0] op;
  logic [DATA_WIDTH-1:0]     opnd [NUM_OPERANDS];
  logic [ERR_CNT_WIDTH-1:0]  err_cnt;

  logic                      is_ctrl, is_result, is_status, bad_addr, xfer_err;
  logic [OPERATION_SIZE-1:0] wr_op;
  logic                      wr_start, wr_clr;
  logic [APB_BUS_SIZE-1:0]   rd_val;
  logic                      pwdata_unused;

  // Only the low operand/control bits of a write carry meaning.
  assign pwdata_unused = ^pwdata;

  assign is_ctrl   = (paddr == '0);
  assign is_result = (paddr == ADDR_RESULT);
  assign is_status = (paddr == ADDR_STATUS);
  assign bad_addr  = (paddr > ADDR_STATUS);
  assign wr_op     = pwdata[OPERATION_SIZE-1:0];
  assign wr_start  = pwdata[OPERATION_SIZE];
  assign wr_clr    = pwdata[OPERATION_SIZE+1];

  assign xfer_err = bad_addr
                  | (pwrite & (is_result | is_status))
                  | (!pwrite & is_result & fifo_out_empty)
                  | (pwrite & is_ctrl & (!OP_VALID_MASK[wr_op] | (wr_start & fifo_in_full)));

  always_comb begin
    rd_val = '0;
    if (is_ctrl) rd_val[OPERATION_SIZE-1:0] = op;
    for (int i = 0; i < NUM_OPERANDS; i++)
      if (paddr == ADDR_WIDTH'(i + 1)) rd_val[DATA_WIDTH-1:0] = opnd[i];
    if (is_status) begin
      rd_val[0] = fifo_out_empty;
      rd_val[1] = fifo_in_full;
      rd_val[ERR_CNT_WIDTH+1:2] = err_cnt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pready       = 1'b0;
    pslverr      = 1'b0;
    prdata       = '0;
    fifo_out_ren = 1'b0;
    case (state)
      IDLE: if (psel && penable) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = IDLE;
        if (xfer_err) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end else if (!pwrite && is_result) begin
          fifo_out_ren = 1'b1;
          state_nxt    = WAIT;
        end else begin
          pready = 1'b1;
          if (!pwrite) prdata = rd_val;
        end
      end
      WAIT: begin
        // Dropping the bus mid-wait abandons the read; the pop already happened.
        if (!(psel && penable)) begin
          state_nxt = IDLE;
        end else if (wait_cnt == CNT_W'(READ_LATENCY)) begin
          pready = 1'b1;
          prdata[FIFO_OUT_WIDTH-1:0] = fifo_out_rdata;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      op            <= '0;
      err_cnt       <= '0;
      fifo_in_wen   <= 1'b0;
      fifo_in_wdata <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) opnd[i] <= '0;
    end else begin
      state       <= state_nxt;
      fifo_in_wen <= 1'b0;
      if (state == ACCESS)    wait_cnt <= CNT_W'(1);
      else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == ACCESS) begin
        if (xfer_err) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end else if (pwrite) begin
          if (is_ctrl) begin
            op <= wr_op;
            if (wr_clr) err_cnt <= '0;
            if (wr_start) begin
              fifo_in_wen <= 1'b1;
              fifo_in_wdata[CMD_W-1 -: OPERATION_SIZE] <= wr_op;
              for (int i = 0; i < NUM_OPERANDS; i++)
                fifo_in_wdata[i*DATA_WIDTH +: DATA_WIDTH] <= opnd[i];
            end
          end
          for (int i = 0; i < NUM_OPERANDS; i++)
            if (paddr == ADDR_WIDTH'(i + 1)) opnd[i] <= pwdata[DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_csr_ctrl_mp.sv
// tb/tb_apb_csr_ctrl_mp.sv - table-driven bench for apb_csr_ctrl_mp with READ_LATENCY=3
module tb_apb_csr_ctrl_mp;

  logic        clk = 1'b0;
  logic        rst_n, psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        fifo_in_full, fifo_in_wen;
  logic [33:0] fifo_in_wdata;
  logic        fifo_out_empty, fifo_out_ren;
  logic [31:0] fifo_out_rdata;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;

  apb_csr_ctrl_mp #(.READ_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .fifo_in_full(fifo_in_full), .fifo_in_wen(fifo_in_wen), .fifo_in_wdata(fifo_in_wdata),
    .fifo_out_empty(fifo_out_empty), .fifo_out_ren(fifo_out_ren), .fifo_out_rdata(fifo_out_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_in_wen)  wen_cnt++;
    if (fifo_out_ren) ren_cnt++;
  end

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic        full;
    logic        empty;
    logic [31:0] rdin;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wen;
    int          exp_ren;
    logic [33:0] exp_wdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic w, logic [2:0] a, logic [31:0] d, logic full, logic empty,
                              logic [31:0] rdin, logic [31:0] exp_rd, logic exp_err, int exp_lat,
                              int exp_wen, int exp_ren, logic [33:0] exp_wdata);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.full = full; v.empty = empty; v.rdin = rdin;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wen = exp_wen; v.exp_ren = exp_ren; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int lat, output logic ren_t0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; rd = '0; err = 1'b0; ren_t0 = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) ren_t0 = fifo_out_ren;
    end while (!pready && lat < 20);
    if (!pready) chk("timeout", 64'(lat), 64'(0));
    rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        err, ren_t0;
  int          lat, w0, r0;

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    fifo_in_full = 1'b0; fifo_out_empty = 1'b1; fifo_out_rdata = '0;

    //        w     a     d             full  empty rdin          exp_rd        err  lat wen ren wdata
    vt.push_back(mk(1'b0, 3'd4, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd1, 32'h1234,     1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd2, 32'hFFFFABCD, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd1, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1234,     1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd2, 32'h0,        1'b0, 1'b1, 32'h0,        32'hABCD,     1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'h5,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1, 1, 0, 34'h1ABCD1234));
    vt.push_back(mk(1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd3, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4, 0, 1, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'h7,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd3, 32'h55,       1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd4, 32'h0,        1'b0, 1'b1, 32'h0,        32'h9,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'h9,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd4, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'h6,        1'b1, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd3, 32'h0,        1'b0, 1'b1, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd5, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd4, 32'h0,        1'b1, 1'b1, 32'h0,        32'hF,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd0, 32'hE,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1, 1, 0, 34'h2ABCD1234));
    vt.push_back(mk(1'b0, 3'd4, 32'h0,        1'b0, 1'b1, 32'h0,        32'h1,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b0, 3'd0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h2,        1'b0, 1, 0, 0, 34'h0));
    vt.push_back(mk(1'b1, 3'd7, 32'h1,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0, 0, 34'h0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pready", 64'(pready), 64'(0));
    chk("reset_pslverr", 64'(pslverr), 64'(0));
    chk("reset_prdata", 64'(prdata), 64'(0));
    chk("reset_wen", 64'(fifo_in_wen), 64'(0));
    chk("reset_ren", 64'(fifo_out_ren), 64'(0));
    rst_n = 1'b1;

    foreach (vt[i]) begin
      fifo_in_full = vt[i].full; fifo_out_empty = vt[i].empty; fifo_out_rdata = vt[i].rdin;
      w0 = wen_cnt; r0 = ren_cnt;
      apb(vt[i].w, vt[i].a, vt[i].d, rd, err, lat, ren_t0);
      chk($sformatf("v%0d_prdata", i), 64'(rd), 64'(vt[i].exp_rd));
      chk($sformatf("v%0d_pslverr", i), 64'(err), 64'(vt[i].exp_err));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("v%0d_wen_pulses", i), 64'(wen_cnt - w0), 64'(vt[i].exp_wen));
      chk($sformatf("v%0d_ren_pulses", i), 64'(ren_cnt - r0), 64'(vt[i].exp_ren));
      chk($sformatf("v%0d_ren_at_t0", i), 64'(ren_t0), 64'(vt[i].exp_ren));
      if (vt[i].exp_wen != 0) chk($sformatf("v%0d_wdata", i), 64'(fifo_in_wdata), 64'(vt[i].exp_wdata));
    end

    // Error counter saturates at all-ones, then a legal err_clr write clears it.
    fifo_in_full = 1'b0; fifo_out_empty = 1'b1;
    for (int k = 0; k < 260; k++) apb(1'b1, 3'd6, 32'h0, rd, err, lat, ren_t0);
    apb(1'b0, 3'd4, 32'h0, rd, err, lat, ren_t0);
    chk("sat_status", 64'(rd), 64'h3FD);
    apb(1'b1, 3'd0, 32'h9, rd, err, lat, ren_t0);
    chk("sat_clr_err", 64'(err), 64'(0));
    apb(1'b0, 3'd4, 32'h0, rd, err, lat, ren_t0);
    chk("sat_clr_status", 64'(rd), 64'h1);

    // Dropping the bus during WAIT abandons the read without pready.
    fifo_out_empty = 1'b0; fifo_out_rdata = 32'hCAFEF00D;
    r0 = ren_cnt;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd3;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    chk("abort_ren_t0", 64'(fifo_out_ren), 64'(1));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (pready) lat++;
    end
    chk("abort_no_pready", 64'(lat), 64'(0));
    chk("abort_ren_pulses", 64'(ren_cnt - r0), 64'(1));

    // Reset during WAIT of a RESULT read.
    apb(1'b1, 3'd1, 32'h7777, rd, err, lat, ren_t0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd3;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1;
    chk("rst_seq_ren_t0", 64'(fifo_out_ren), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_seq_pready", 64'(pready), 64'(0));
    chk("rst_seq_prdata", 64'(prdata), 64'(0));
    chk("rst_seq_ren", 64'(fifo_out_ren), 64'(0));
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    fifo_out_empty = 1'b1;
    apb(1'b0, 3'd4, 32'h0, rd, err, lat, ren_t0);
    chk("post_rst_status", 64'(rd), 64'h1);
    chk("post_rst_status_lat", 64'(lat), 64'(1));
    chk("post_rst_status_err", 64'(err), 64'(0));
    apb(1'b0, 3'd1, 32'h0, rd, err, lat, ren_t0);
    chk("post_rst_opnd0", 64'(rd), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_csr_ctrl_mp.md
Name: apb_csr_ctrl_mp

Overview:
Next-generation APB slave CSR controller for the ALU subsystem. It generalises the CSR front end to NUM_OPERANDS operand registers, a programmable legal-opcode mask and a parametrised FIFO_OUT read latency (and so a parametrised number of wait states). It adds register readback, a saturating error counter with software clear, and a packed command push to FIFO_IN. It sits between the APB bus and the ALU's FIFO_IN/FIFO_OUT, and owns all operand/control storage.

Parameters:
NUM_OPERANDS, 2, number of operand registers (1..8)
DATA_WIDTH, 16, operand width (<= APB_BUS_SIZE)
OPERATION_SIZE, 2, opcode width
OP_VALID_MASK, 4'b0110, bit k=1 means opcode k is legal (width 2**OPERATION_SIZE)
FIFO_OUT_WIDTH, 32, result width (<= APB_BUS_SIZE)
APB_BUS_SIZE, 32, pwdata/prdata width
READ_LATENCY, 1, cycles from fifo_out_ren to valid fifo_out_rdata (>=1)
ERR_CNT_WIDTH, 8, error counter width
ADDR_WIDTH, $clog2(NUM_OPERANDS+3), derived

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  ADDR_WIDTH  register address
pwdata  in  APB_BUS_SIZE  write data
prdata  out  APB_BUS_SIZE  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error (valid only with pready)
fifo_in_full  in  1  FIFO_IN full
fifo_in_wen  out  1  FIFO_IN push strobe
fifo_in_wdata  out  OPERATION_SIZE+NUM_OPERANDS*DATA_WIDTH  packed command {op, opnd[N-1]..opnd[0]}
fifo_out_empty  in  1  FIFO_OUT empty
fifo_out_ren  out  1  FIFO_OUT pop strobe
fifo_out_rdata  in  FIFO_OUT_WIDTH  FIFO_OUT head data

Behaviour:
- Map: 0 CTRL (RW: [OPERATION_SIZE-1:0] op, [OPERATION_SIZE] start, [OPERATION_SIZE+1] err_clr; start/err_clr write-only, read as 0); 1..N OPND[i-1] (RW); N+1 RESULT (RO, read pops FIFO_OUT); N+2 STATUS (RO: [0] fifo_out_empty, [1] fifo_in_full, [ERR_CNT_WIDTH+1:2] err_cnt).
- Reset (rst_n low at a clk edge): FSM IDLE; op, operands, err_cnt = 0; pready, pslverr, fifo_in_wen, fifo_out_ren = 0; prdata = 0. Reset mid-transfer aborts it, and outputs are 0 from the next cycle.
- FSM: IDLE -> ACCESS when psel&penable. ACCESS -> IDLE for a zero-wait or error transfer. ACCESS -> WAIT for a legal RESULT read. WAIT counts READ_LATENCY cycles, then -> IDLE. psel or penable low while in WAIT -> IDLE (abort; a pop already issued stands).
- Errors (decoded in ACCESS; pslverr=1 with pready=1 in the same cycle, zero wait, no side effects): paddr > N+2; write to RESULT or STATUS; read of RESULT with fifo_out_empty; CTRL write with OP_VALID_MASK[op]==0; CTRL write with start=1 and fifo_in_full.
- Writes: zero wait states, pready=1 in the first ACCESS cycle, and the register updates at that edge. Operands take pwdata[DATA_WIDTH-1:0].
- Push: a legal CTRL write with start=1 causes fifo_in_wen=1 for exactly one cycle, in the cycle after ACCESS. fifo_in_wdata is registered {new op, operands}.
- Non-RESULT reads: zero wait. prdata is the register value, zero-extended, in the first ACCESS cycle.
- RESULT read: fifo_out_ren=1 for one cycle during the first ACCESS cycle T0. pready=1 in cycle T0+READ_LATENCY with prdata = zero-extended fifo_out_rdata. This gives READ_LATENCY wait states.
- prdata = 0 whenever pready=0 or pslverr=1.
- err_cnt increments on every erroring transfer and saturates at all-ones.
- err_clr=1 in a legal CTRL write zeroes err_cnt. A CTRL write carrying err_clr that also errors does not clear; the counter increments instead.
- A CTRL write with start=1 and err_clr=1 does both.

Test Plan:
- Reset, then read STATUS with FIFO_OUT empty -> pready in the 1st ACCESS cycle, prdata=0x1, pslverr=0.
- Write OPND0=0x1234, OPND1=0xABCD, then CTRL=0x5 (op=1, start) -> fifo_in_wen pulses 1 cycle; fifo_in_wdata={2'b01,16'hABCD,16'h1234}.
- READ_LATENCY=3, FIFO_OUT holding 0xDEADBEEF, read RESULT -> fifo_out_ren pulses once at T0; pready=1 at T0+3 with prdata=0xDEADBEEF.
- CTRL write op=3 with start -> pslverr=1, no push, err_cnt=1. Then write to RESULT -> err_cnt=2. Then CTRL=0x9 (op=1, err_clr) -> err_cnt=0.
- fifo_in_full=1, CTRL start write -> pslverr=1, fifo_in_wen stays 0. RESULT read with fifo_out_empty=1 -> pslverr=1, no ren.
- Assert rst_n low during WAIT of a RESULT read -> next cycle pready=0, FSM IDLE, operands 0. The following STATUS read completes normally.
